// File: rtl/random_picker_pkg.sv
// ----------------------------------------------------------------------------
// random_picker_pkg
// Shared definitions for the bounded random picker: FSM state encoding and
// the default data width / limit constants also used by the LFSR and the
// seven-segment display decoder.
// ----------------------------------------------------------------------------
package random_picker_pkg;

    // Picker FSM states, 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // Default stream width and largest acceptable digit (0..9)
    localparam int unsigned RP_WIDTH     = 4;
    localparam int unsigned RP_LIMIT     = 9;
    localparam int unsigned RP_MAX_TRIES = 8;

    // Width of the rejected-draw counter
    localparam int unsigned RP_CNT_W     = 8;

endpackage : random_picker_pkg

// File: rtl/random_picker_if.sv
// ----------------------------------------------------------------------------
// random_picker_if
// Bundles the LFSR input, the request/ack handshake and the picked value.
//   random : LFSR stream into the picker (changes every cycle)
//   req    : draw request from the consumer
//   ack    : consumer has taken value
//   value  : accepted random value, stable while valid
//   valid  : value holds an unconsumed draw
//   busy   : picker is drawing or holding a result
// Modports: master = consumer/stimulus side, slave = picker side.
// ----------------------------------------------------------------------------
interface random_picker_if
    import random_picker_pkg::*;
#(
    parameter int unsigned WIDTH = RP_WIDTH
) ();

    logic [WIDTH-1:0] random;
    logic             req;
    logic             ack;
    logic [WIDTH-1:0] value;
    logic             valid;
    logic             busy;

    modport master (
        output random,
        output req,
        output ack,
        input  value,
        input  valid,
        input  busy
    );

    modport slave (
        input  random,
        input  req,
        input  ack,
        output value,
        output valid,
        output busy
    );

endinterface : random_picker_if

// File: rtl/random_picker_draw_filter.sv
// ----------------------------------------------------------------------------
// draw_filter
// Combinational accept/reject decision for one draw of the random stream.
//   random_i    : candidate value
//   last_i      : previously delivered value
//   no_repeat_i : when high, a candidate equal to last_i is rejected too
//   accept_o    : candidate is usable (unsigned random_i <= LIMIT, and not
//                 a repeat when no_repeat_i is set)
// ----------------------------------------------------------------------------
module draw_filter
    import random_picker_pkg::*;
#(
    parameter int unsigned WIDTH = RP_WIDTH,
    parameter int unsigned LIMIT = RP_LIMIT
) (
    input  logic [WIDTH-1:0] random_i,
    input  logic [WIDTH-1:0] last_i,
    input  logic             no_repeat_i,
    output logic             accept_o
);

    localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(LIMIT);

    // Range check plus optional repeat rejection
    always_comb begin
        accept_o = 1'b0;
        if (random_i <= LIMIT_W) begin
            accept_o = !(no_repeat_i && (random_i == last_i));
        end else begin
            accept_o = 1'b0;
        end
    end

endmodule : draw_filter

// File: rtl/random_picker.sv
// ----------------------------------------------------------------------------
// random_picker
// Draws bounded random values from a free-running LFSR stream. A request in
// IDLE starts a DRAW phase that samples the stream every cycle and keeps the
// first value in 0..LIMIT. After MAX_TRIES rejected draws a deterministic
// fallback (last+1, wrapping to 0 after LIMIT) is used instead, so the result
// always arrives within MAX_TRIES+2 cycles of the request edge. The result is
// held with valid=1 until the consumer acks it.
//
// Ports:
//   clk     : sole clock
//   rst     : synchronous, active-high reset
//   pick_if : random_picker_if.slave (random/req/ack in, value/valid/busy out)
//
// Build option: define RANDOM_PICKER_NO_REPEAT_EN to also reject a draw equal
// to the previously delivered value, so consecutive outputs never repeat.
// ----------------------------------------------------------------------------
module random_picker
    import random_picker_pkg::*;
#(
    parameter int unsigned WIDTH     = RP_WIDTH,
    parameter int unsigned LIMIT     = RP_LIMIT,
    parameter int unsigned MAX_TRIES = RP_MAX_TRIES
) (
    input  logic           clk,
    input  logic           rst,
    random_picker_if.slave pick_if
);

    localparam logic [WIDTH-1:0]    LIMIT_W = WIDTH'(LIMIT);
    localparam logic [RP_CNT_W-1:0] MAX_T_W = RP_CNT_W'(MAX_TRIES);

`ifdef RANDOM_PICKER_NO_REPEAT_EN
    localparam logic NO_REPEAT = 1'b1;
`else
    localparam logic NO_REPEAT = 1'b0;
`endif

    state_e              state_q;
    logic [RP_CNT_W-1:0] tries_q;
    logic [WIDTH-1:0]    value_q;
    logic [WIDTH-1:0]    last_q;
    logic                valid_q;
    logic                busy_q;

    logic                accept_d;
    logic [WIDTH-1:0]    fallback_d;

    draw_filter #(
        .WIDTH (WIDTH),
        .LIMIT (LIMIT)
    ) u_draw_filter (
        .random_i    (pick_if.random),
        .last_i      (last_q),
        .no_repeat_i (NO_REPEAT),
        .accept_o    (accept_d)
    );

    // Fallback is always in range and differs from last unless LIMIT is 0
    always_comb begin
        fallback_d = '0;
        if (last_q == LIMIT_W) begin
            fallback_d = '0;
        end else begin
            fallback_d = last_q + WIDTH'(1);
        end
    end

    // Picker FSM with try counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tries_q <= '0;
            value_q <= '0;
            last_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tries_q <= '0;
                    valid_q <= 1'b0;
                    if (pick_if.req) begin
                        state_q <= ST_DRAW;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                ST_DRAW: begin
                    // Fallback has priority once the reject budget is spent,
                    // which bounds the latency regardless of the stream.
                    if (tries_q >= MAX_T_W) begin
                        value_q <= fallback_d;
                        last_q  <= fallback_d;
                        valid_q <= 1'b1;
                        state_q <= ST_HOLD;
                    end else if (accept_d) begin
                        value_q <= pick_if.random;
                        last_q  <= pick_if.random;
                        valid_q <= 1'b1;
                        state_q <= ST_HOLD;
                    end else begin
                        tries_q <= tries_q + RP_CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    // req is ignored here; ack returns to IDLE and value stays
                    if (pick_if.ack) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pick_if.value = value_q;
    assign pick_if.valid = valid_q;
    assign pick_if.busy  = busy_q;

endmodule : random_picker

// File: tb/tb_random_picker.sv
// ----------------------------------------------------------------------------
// tb_random_picker
// Transaction-level reference: for each request the bench decides the draws
// it will present, predicts the result (first acceptable draw, or the
// fallback after MAX_TRIES rejects) and the cycle it appears, and a compare
// process checks valid/busy/value against that prediction on every cycle.
// ----------------------------------------------------------------------------
module tb_random_picker;

    localparam int W   = 4;
    localparam int LIM = 9;
    localparam int MT  = 8;

`ifdef RANDOM_PICKER_NO_REPEAT_EN
    localparam bit NR = 1'b1;
`else
    localparam bit NR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    random_picker_if #(.WIDTH(W)) pif ();

    random_picker #(
        .WIDTH     (W),
        .LIMIT     (LIM),
        .MAX_TRIES (MT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .pick_if (pif)
    );

    int errors = 0;
    int checks = 0;

    bit cmp_en = 1'b0;
    bit exp_valid;
    bit exp_busy;
    int exp_value;
    int m_last;

    int pend_q[$];
    int draws[1:MT];
    int p_val;
    int p_k;
    int p_lat;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the predicted outputs
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_valid", int'(pif.valid), int'(exp_valid));
            check("cyc_busy",  int'(pif.busy),  int'(exp_busy));
            check("cyc_value", int'(pif.value), exp_value);
        end
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit usable(input int d, input int last);
        return (d <= LIM) && !(NR && (d == last));
    endfunction

    // Result: first usable draw, else last+1 (wrap after LIM) on draw MT+1
    task automatic predict(input int last, output int val, output int k);
        for (int j = 1; j <= MT; j++) begin
            if (usable(draws[j], last)) begin
                val = draws[j];
                k   = j;
                return;
            end
        end
        val = (last == LIM) ? 0 : ((last + 1) % (1 << W));
        k   = MT + 1;
    endtask

    // One request; ack_wait < 0 leaves the picker holding its result
    task automatic txn(input bit hold_req, input int ack_wait, input bit ack_with_req);
        for (int j = 1; j <= MT; j++) begin
            if (pend_q.size() > 0) draws[j] = pend_q.pop_front();
            else                   draws[j] = int'($urandom_range(0, 15));
        end
        predict(m_last, p_val, p_k);
        p_lat = p_k + 1;

        pif.req    = 1'b1;
        pif.ack    = 1'b0;
        pif.random = 4'($urandom);
        tick();
        exp_busy  = 1'b1;
        exp_valid = 1'b0;
        pif.req   = hold_req;

        for (int k = 1; k <= p_k; k++) begin
            if (k <= MT) pif.random = 4'(draws[k]);
            else         pif.random = 4'($urandom);
            tick();
        end
        exp_valid = 1'b1;
        exp_value = p_val;
        m_last    = p_val;

        if (ack_wait >= 0) begin
            repeat (ack_wait) begin
                pif.random = 4'($urandom);
                tick();
            end
            pif.ack = 1'b1;
            pif.req = ack_with_req;
            tick();
            exp_valid = 1'b0;
            exp_busy  = 1'b0;
            pif.ack   = 1'b0;
        end
    endtask

    initial begin
        rst        = 1'b1;
        pif.req    = 1'b0;
        pif.ack    = 1'b0;
        pif.random = '0;
        exp_valid  = 1'b0;
        exp_busy   = 1'b0;
        exp_value  = 0;
        m_last     = 0;
        tick();
        cmp_en = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("reset_valid", int'(pif.valid), 0);
        check("reset_busy",  int'(pif.busy),  0);
        check("reset_value", int'(pif.value), 0);

        // ack while idle has no effect
        pif.ack = 1'b1;
        repeat (2) tick();
        pif.ack = 1'b0;
        tick();
        check("idle_ack_busy", int'(pif.busy), 0);

        // In-range draw on the first evaluated cycle
        pend_q = '{5};
        txn(1'b0, 0, 1'b0);
        check("inrange_value", int'(pif.value), 5);
        check("inrange_lat", p_lat, 2);

        // Two rejects then an accept
        pend_q = '{12, 14, 3};
        txn(1'b0, 1, 1'b0);
        check("reject_value", int'(pif.value), 3);
        check("reject_lat", p_lat, 4);

        // Repeat handling after a previous 7
        pend_q = '{7};
        txn(1'b0, 0, 1'b0);
        pend_q = '{7, 7, 2};
        txn(1'b0, 0, 1'b0);
        if (NR) begin
            check("norepeat_value", int'(pif.value), 2);
            check("norepeat_lat", p_lat, 4);
        end else begin
            check("repeat_value", int'(pif.value), 7);
            check("repeat_lat", p_lat, 2);
        end

        // Fallback wraps last=9 to 0 after MT rejects
        pend_q = '{9};
        txn(1'b0, 0, 1'b0);
        pend_q = '{15, 15, 15, 15, 15, 15, 15, 15};
        txn(1'b0, 2, 1'b0);
        check("fallback_value", int'(pif.value), 0);
        check("fallback_lat", p_lat, 10);

        // req held through HOLD, then ack together with req, then redraw
        pend_q = '{1};
        txn(1'b1, 3, 1'b1);
        pend_q = '{8};
        txn(1'b0, 0, 1'b0);
        check("reqack_value", int'(pif.value), 8);

        // Reset while holding a result
        pend_q = '{6};
        txn(1'b0, -1, 1'b0);
        check("prehold_valid", int'(pif.valid), 1);
        rst = 1'b1;
        tick();
        exp_valid = 1'b0;
        exp_busy  = 1'b0;
        exp_value = 0;
        m_last    = 0;
        tick();
        rst = 1'b0;
        tick();
        check("rst_hold_valid", int'(pif.valid), 0);
        check("rst_hold_value", int'(pif.value), 0);
        pend_q = '{4};
        txn(1'b0, 0, 1'b0);
        check("post_rst_value", int'(pif.value), 4);

        // Randomised transactions
        repeat (60) begin
            txn(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)));
        end

        pif.req = 1'b0;
        repeat (3) tick();
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_random_picker
